// File: rtl/irq_timer_if.sv
// Peripheral bus bundle between the CPU data port and the interval timer.
interface irq_timer_if;
  logic [31:0] Address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output Address,
    output MemRead,
    output MemWrite,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  Address,
    input  MemRead,
    input  MemWrite,
    input  WriteData,
    output ReadData
  );
endinterface

// File: rtl/irq_timer.sv
// Memory-mapped interval timer driving the CPU IRQ line.
// Define TIMER_ONESHOT_EN to add TCON[3] one-shot mode.
module irq_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1,
  parameter int          PS_W      = 16
) (
  input  logic      clk,
  input  logic      reset,
  irq_timer_if.slave bus,
  output logic      IRQ
);

`ifdef TIMER_ONESHOT_EN
  localparam int TW = 4;
`else
  localparam int TW = 3;
`endif

  localparam logic [31:0] A_TH   = BASE_ADDR;
  localparam logic [31:0] A_TL   = BASE_ADDR + 32'd4;
  localparam logic [31:0] A_TCON = BASE_ADDR + 32'd8;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [31:0]   th_q, th_d;
  logic [31:0]   tl_q, tl_d;
  logic [TW-1:0] tcon_q, tcon_d;
  logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;

  logic sel_th, sel_tl, sel_tcon;
  logic wr_th, wr_tl, wr_tcon;
  logic tick, ovf, set_irq, stop;

  always_comb begin
    sel_th   = (bus.Address == A_TH);
    sel_tl   = (bus.Address == A_TL);
    sel_tcon = (bus.Address == A_TCON);
    wr_th    = bus.MemWrite && sel_th;
    wr_tl    = bus.MemWrite && sel_tl;
    wr_tcon  = bus.MemWrite && sel_tcon;
  end

  always_comb begin
    tick    = tcon_q[0] && (ps_cnt_q == PS_LAST);
    ovf     = tick && (tl_q == 32'hFFFF_FFFF);
    set_irq = ovf && tcon_q[1];
`ifdef TIMER_ONESHOT_EN
    stop    = ovf && tcon_q[3];
`else
    stop    = 1'b0;
`endif
  end

  always_comb begin
    th_d = th_q;
    if (wr_th)
      th_d = bus.WriteData;
  end

  // A bus write to TL beats a same-edge tick; overflow reloads old TH.
  always_comb begin
    tl_d = tl_q;
    if (tick)
      tl_d = ovf ? th_q : tl_q + 32'd1;
    if (wr_tl)
      tl_d = bus.WriteData;
  end

  // Status set by overflow survives a colliding acknowledge write.
  always_comb begin
    tcon_d = tcon_q;
    if (wr_tcon)
      tcon_d = bus.WriteData[TW-1:0];
    if (set_irq)
      tcon_d[2] = 1'b1;
    if (stop)
      tcon_d[0] = 1'b0;
  end

  always_comb begin
    ps_cnt_d = ps_cnt_q + PS_W'(1);
    if (!tcon_q[0] || !tcon_d[0] || tick)
      ps_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q     <= '0;
      tl_q     <= '0;
      tcon_q   <= '0;
      ps_cnt_q <= '0;
    end else begin
      th_q     <= th_d;
      tl_q     <= tl_d;
      tcon_q   <= tcon_d;
      ps_cnt_q <= ps_cnt_d;
    end
  end

  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead) begin
      unique case (1'b1)
        sel_th:   bus.ReadData = th_q;
        sel_tl:   bus.ReadData = tl_q;
        sel_tcon: bus.ReadData = 32'(tcon_q);
        default:  bus.ReadData = '0;
      endcase
    end
  end

  assign IRQ = tcon_q[2];

endmodule

// File: tb/tb_irq_timer.sv
// Scoreboard bench for irq_timer: PRESCALE=1 and PRESCALE=4 instances.
module tb_irq_timer;
  localparam logic [31:0] B = 32'h4000_0000;
  localparam logic [31:0] A_TH = B;
  localparam logic [31:0] A_TL = B + 32'd4;
  localparam logic [31:0] A_TC = B + 32'd8;

  typedef struct {
    bit          sel;
    logic [31:0] rd;
    logic        irq;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq1, irq4;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  irq_timer_if b1 ();
  irq_timer_if b4 ();

  irq_timer #(.BASE_ADDR(B), .PRESCALE(1)) u_d1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave),
    .IRQ   (irq1)
  );

  irq_timer #(.BASE_ADDR(B), .PRESCALE(4)) u_d4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave),
    .IRQ   (irq4)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b1.MemRead = 1'b0; b1.MemWrite = 1'b0;
    b4.MemRead = 1'b0; b4.MemWrite = 1'b0;
  endtask

  task automatic wr(bit sel, logic [31:0] a, logic [31:0] d);
    if (sel) begin
      b4.Address = a; b4.WriteData = d; b4.MemWrite = 1'b1;
    end else begin
      b1.Address = a; b1.WriteData = d; b1.MemWrite = 1'b1;
    end
    cyc();
    idle();
  endtask

  task automatic rd(bit sel, logic [31:0] a, logic [31:0] e,
                    logic ei, string nm);
    exp_t x;
    x.sel = sel; x.rd = e; x.irq = ei; x.name = nm;
    sb.push_back(x);
    if (sel) begin
      b4.Address = a; b4.MemRead = 1'b1;
    end else begin
      b1.Address = a; b1.MemRead = 1'b1;
    end
    cyc();
    idle();
  endtask

  always @(negedge clk) begin
    if (b1.MemRead || b4.MemRead) begin
      logic [31:0] a_rd;
      logic        a_irq;
      exp_t        x;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_read: no expectation queued");
      end else begin
        x = sb.pop_front();
        a_rd  = x.sel ? b4.ReadData : b1.ReadData;
        a_irq = x.sel ? irq4 : irq1;
        n_chk++;
        if (a_rd === x.rd) n_pass++;
        else $display("FAIL %s rdata: got %h want %h",
                      x.name, a_rd, x.rd);
        n_chk++;
        if (a_irq === x.irq) n_pass++;
        else $display("FAIL %s irq: got %b want %b",
                      x.name, a_irq, x.irq);
      end
    end
  end

  initial begin
    b1.Address = '0; b1.WriteData = '0;
    b4.Address = '0; b4.WriteData = '0;
    idle();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;

    rd(0, A_TH, 32'h0, 1'b0, "rst_th");
    rd(0, A_TL, 32'h0, 1'b0, "rst_tl");
    rd(0, A_TC, 32'h0, 1'b0, "rst_tcon");
    rd(1, A_TC, 32'h0, 1'b0, "rst_tcon4");

    // overflow and auto-reload
    wr(0, A_TH, 32'hFFFF_FFF0);
    wr(0, A_TL, 32'hFFFF_FFFE);
    wr(0, A_TC, 32'h3);
    rd(0, A_TL, 32'hFFFF_FFFE, 1'b0, "ovf_pre2");
    rd(0, A_TL, 32'hFFFF_FFFF, 1'b0, "ovf_pre1");
    rd(0, A_TL, 32'hFFFF_FFF0, 1'b1, "ovf_reload");
    rd(0, A_TC, 32'h7, 1'b1, "ovf_tcon");
    rd(0, A_TL, 32'hFFFF_FFF2, 1'b1, "ovf_counting");

    // acknowledge
    wr(0, A_TC, 32'h3);
    rd(0, A_TC, 32'h3, 1'b0, "ack_tcon");
    rd(0, A_TL, 32'hFFFF_FFF5, 1'b0, "ack_tl");

    // ack collides with overflow
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TC, 32'h3);
    rd(0, A_TC, 32'h7, 1'b1, "coll_tcon");
    rd(0, A_TL, 32'hFFFF_FFF1, 1'b1, "coll_tl");

    // TL write beats tick; TH write on overflow edge
    wr(0, A_TL, 32'h5);
    rd(0, A_TL, 32'h5, 1'b1, "tlwr_wins");
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TH, 32'h100);
    rd(0, A_TL, 32'hFFFF_FFF0, 1'b1, "thwr_oldth");
    rd(0, A_TH, 32'h100, 1'b1, "thwr_newth");

    // decode
    rd(0, B + 32'd12, 32'h0, 1'b1, "dec_plus12");
    rd(0, B + 32'd2, 32'h0, 1'b1, "dec_plus2");

    // prescaler
    wr(1, A_TL, 32'h0);
    wr(1, A_TC, 32'h1);
    repeat (12) cyc();
    wr(1, A_TC, 32'h0);
    repeat (5) cyc();
    rd(1, A_TL, 32'h3, 1'b0, "ps_hold");
    wr(1, A_TL, 32'hFFFF_FFFF);
    wr(1, A_TC, 32'h1);
    repeat (3) cyc();
    rd(1, A_TL, 32'hFFFF_FFFF, 1'b0, "ps_pre_ovf");
    rd(1, A_TL, 32'h0, 1'b0, "ps_ovf_noie");
    rd(1, A_TC, 32'h1, 1'b0, "ps_tcon_noie");

`ifdef TIMER_ONESHOT_EN
    wr(0, A_TC, 32'h0);
    wr(0, A_TL, 32'hFFFF_FFFF);
    wr(0, A_TC, 32'hB);
    rd(0, A_TL, 32'hFFFF_FFFF, 1'b0, "os_pre");
    rd(0, A_TC, 32'hE, 1'b1, "os_tcon");
    rd(0, A_TL, 32'h100, 1'b1, "os_halt");
`endif

    // reset mid-count
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd(0, A_TL, 32'h0, 1'b0, "rst2_tl");
    rd(0, A_TC, 32'h0, 1'b0, "rst2_tcon");
    rd(0, A_TH, 32'h0, 1'b0, "rst2_th");

    repeat (2) cyc();
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d left want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/irq_timer.md
Name: irq_timer

Overview:
- Memory-mapped interval timer that sources the `IRQ` input of the CPU control decoder.
- Lives on the peripheral bus beside data memory and is selected by address.
- The CPU loads a reload value and a counter value. The counter increments until it overflows, then reloads and raises `IRQ`.
- The interrupt handler acknowledges by clearing the status bit through a bus write.

Parameters:
- BASE_ADDR, 32'h40000000, byte address of register TH. TL is at BASE_ADDR+4, TCON at BASE_ADDR+8.
- PRESCALE, 1, clock cycles per counter tick. Legal range 1..65535.
- PS_W, 16, prescaler counter width. Must satisfy 2^PS_W >= PRESCALE.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- Address  input  32  bus byte address. Only word-aligned matches decode.
- MemRead  input  1  read strobe.
- MemWrite  input  1  write strobe, sampled on the rising edge of clk.
- WriteData  input  32  write data.
- ReadData  output  32  combinational read data.
- IRQ  output  1  interrupt request to the control unit. Level signal, equal to TCON[2].

Behaviour:
- Registers:
  - TH[31:0]: reload value.
  - TL[31:0]: counter.
  - TCON[2:0]: bit 0 = count enable, bit 1 = interrupt enable, bit 2 = interrupt status. Bits above 2 read as 0.
- Reset (synchronous, on the clk edge with reset=1):
  - TH, TL, TCON and the prescaler count `ps_cnt` all clear to 0.
  - IRQ=0.
  - Reset mid-count discards all state. Reset has priority over writes and ticks.
- Read path:
  - When MemRead=1 and Address equals one of the three register addresses, ReadData returns that register in the same cycle (zero latency).
  - In every other case ReadData=0, including unaligned or unmapped addresses and MemRead=0.
- Write path:
  - When MemWrite=1 and Address matches, the register updates at the clk edge.
  - A write to TCON stores WriteData[2:0].
  - Writes to unmapped addresses are ignored.
- Prescaler:
  - While TCON[0]=0, `ps_cnt` holds at 0 and no tick occurs.
  - While TCON[0]=1, `ps_cnt` counts 0..PRESCALE-1 and wraps to 0.
  - `tick` is asserted in the cycle where `ps_cnt`==PRESCALE-1. With PRESCALE=1, tick is asserted every enabled cycle.
  - A write that clears TCON[0] resets `ps_cnt` to 0 at the next edge.
- Counting on tick:
  - If TL != 32'hFFFFFFFF, then TL <= TL+1.
  - If TL == 32'hFFFFFFFF (overflow), then TL <= TH. In addition, if TCON[1]=1, TCON[2] <= 1.
- Simultaneous events, at one edge:
  - Bus write to TL together with a tick: the write wins and the tick is lost.
  - Bus write to TH together with overflow: TL takes the old TH. The new TH applies from the next overflow.
  - Bus write to TCON together with an overflow that sets status: TCON takes WriteData[2:0], except that bit 2 is forced to 1. The interrupt is never lost.
  - A write to TCON with bit 2=0 and no concurrent overflow clears IRQ at the next edge. This is the acknowledge.
- IRQ:
  - Registered; rises in the cycle after the overflow edge.
  - Stays high until cleared by software or by reset.
  - Clearing TCON[1] does not clear an already-set TCON[2].

Optional Feature:
- Macro TIMER_ONESHOT_EN.
- Defined:
  - TCON gains bit 3, one-shot mode: readable, writable, reset 0.
  - On overflow with TCON[3]=1, TL reloads as normal and TCON[0] clears at the same edge, so counting stops.
  - With the macro defined, the forced status bit in the write/overflow collision rule still applies. TCON[0] follows the one-shot clear, so that edge stores TCON[0]=0.
- Undefined: TCON is 3 bits, bit 3 reads 0 and writes to it are ignored. The timer always auto-reloads.

Test Plan:
- Reset then read: assert reset 1 cycle, then read each of the 3 addresses -> ReadData=0 for all, IRQ=0.
- Overflow and auto-reload: PRESCALE=1, write TH=32'hFFFFFFF0, TL=32'hFFFFFFFE, TCON=3'b011 -> TL goes to FFFFFFFF, then FFFFFFF0; IRQ=1 on the cycle after the reload edge; TL keeps counting.
- Acknowledge: with IRQ=1 and TL far from overflow, write TCON=3'b011 -> IRQ=0 next cycle; TL unaffected.
- Ack collides with overflow: write TCON=3'b011 on the exact overflow edge -> TCON reads 3'b111 and IRQ stays 1.
- Prescaler: PRESCALE=4, TL=0, TCON=3'b001 for 12 cycles -> TL=3. Clear TCON[0], wait 5 cycles -> TL still 3. Interrupt disabled (TCON[1]=0) throughout, overflow with TCON[1]=0 -> IRQ stays 0.
- Decode and one-shot: read BASE_ADDR+12 and BASE_ADDR+2 -> ReadData=0. With TIMER_ONESHOT_EN defined, TCON=4'b1011 and TL=FFFFFFFF -> after tick, TL=TH, TCON reads 4'b1110, counting halts.
